// File: rtl/sw_debounce_ctrl_pkg.sv
// Shared types and default sizing for the panel-switch debounce controller.
package sw_pkg;

    localparam int N_SW_DEF         = 4;
    localparam int DIV_BITS_DEF     = 15;
    localparam int STABLE_TICKS_DEF = 4;
    localparam int FIFO_DEPTH_DEF   = 4;
    // Event id field is sized for the largest bank so the struct is fixed.
    localparam int ID_MAX_W         = 4;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int ID_W  = id_width(N_SW_DEF);
    localparam int CNT_W = $clog2(STABLE_TICKS_DEF);

    typedef struct packed {
        logic [ID_MAX_W-1:0] id;
        logic                press;
    } evt_t;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } scan_state_e;

endpackage

// File: rtl/sw_debounce_chk.sv
// Checker: the sample tick must never arrive while a scan is still running.
module sw_debounce_chk (
    input logic clk_i,
    input logic rst_i,
    input logic tick_i,
    input logic scan_i
);

    a_tick_not_in_scan: assert property (@(posedge clk_i) disable iff (rst_i) !(tick_i && scan_i));

endmodule

// File: rtl/sw_evt_fifo.sv
// Show-ahead synchronous event queue; a push into a full queue succeeds only
// when a pop happens in the same cycle.
module sw_evt_fifo
    import sw_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic push_i,
    input  evt_t din_i,
    input  logic pop_i,
    output logic full_o,
    output logic empty_o,
    output evt_t head_o
);

    localparam int PW = $clog2(DEPTH);

    evt_t         mem_q [DEPTH];
    logic [PW:0]  wr_q;
    logic [PW:0]  rd_q;
    logic         do_push_s;
    logic         do_pop_s;

    assign empty_o   = (wr_q == rd_q);
    assign full_o    = (wr_q[PW] != rd_q[PW]) && (wr_q[PW-1:0] == rd_q[PW-1:0]);
    assign do_pop_s  = pop_i && !empty_o;
    assign do_push_s = push_i && (!full_o || do_pop_s);
    assign head_o    = mem_q[rd_q[PW-1:0]];

    // Storage and wrap-bit pointers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_q <= '0;
            rd_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (do_push_s) begin
                mem_q[wr_q[PW-1:0]] <= din_i;
                wr_q                <= wr_q + {{PW{1'b0}}, 1'b1};
            end
            if (do_pop_s) begin
                rd_q <= rd_q + {{PW{1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: rtl/sw_debounce_ctrl.sv
// Panel-switch bank debouncer: prescaled sample tick, round-robin scan of each
// switch, per-switch stability counters and a press/release event queue.
module sw_debounce_ctrl
    import sw_pkg::*;
#(
    parameter int N_SW         = N_SW_DEF,
    parameter int DIV_BITS     = DIV_BITS_DEF,
    parameter int STABLE_TICKS = STABLE_TICKS_DEF,
    parameter int FIFO_DEPTH   = FIFO_DEPTH_DEF,
    localparam int IDW         = id_width(N_SW),
    localparam int CW          = $clog2(STABLE_TICKS)
) (
    input  logic            CLK_33,
    input  logic            RST,
    input  logic [N_SW-1:0] nSW_IN,
    output logic [N_SW-1:0] SW_STATE,
    output logic            EVT_VALID,
    input  logic            EVT_READY,
    output logic [IDW-1:0]  EVT_ID,
    output logic            EVT_PRESS,
    output logic            EVT_OVF,
    input  logic            OVF_CLR
);

    logic [DIV_BITS-1:0] presc_q;
    logic [N_SW-1:0]     sync1_q, sync2_q, sample_s;
    scan_state_e         state_q, state_d;
    logic [IDW-1:0]      idx_q, idx_d;
    logic [CW-1:0]       cnt_q [N_SW];
    logic [CW-1:0]       cnt_d [N_SW];
    logic [N_SW-1:0]     sw_q, sw_d;
    logic                ovf_q, ovf_d;
    logic                tick_s, push_s, pop_s, full_s, empty_s;
    evt_t                evt_s, head_s;

    assign tick_s   = &presc_q;
    assign sample_s = ~sync2_q;
    assign pop_s    = EVT_READY && !empty_s;

    // Prescaler, synchronizer and scan/debounce state.
    always_ff @(posedge CLK_33 or posedge RST) begin
        if (RST) begin
            presc_q <= '0;
            sync1_q <= '0;
            sync2_q <= '0;
            state_q <= IDLE;
            idx_q   <= '0;
            sw_q    <= '0;
            ovf_q   <= 1'b0;
            for (int i = 0; i < N_SW; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            presc_q <= presc_q + {{(DIV_BITS-1){1'b0}}, 1'b1};
            sync1_q <= nSW_IN;
            sync2_q <= sync1_q;
            state_q <= state_d;
            idx_q   <= idx_d;
            sw_q    <= sw_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
        end
    end

    // Scan sequencing and the debounce step for the switch under the index.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        sw_d    = sw_q;
        push_s  = 1'b0;
        evt_s   = '0;
        case (state_q)
            IDLE: begin
                if (tick_s) begin
                    state_d = SCAN;
                    idx_d   = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            SCAN: begin
                // An agreeing sample restarts the count so short bounces vanish.
                if (sample_s[idx_q] == sw_q[idx_q]) begin
                    cnt_d[idx_q] = '0;
                end else if (cnt_q[idx_q] == CW'(STABLE_TICKS - 1)) begin
                    sw_d[idx_q]  = sample_s[idx_q];
                    cnt_d[idx_q] = '0;
                    push_s       = 1'b1;
                    evt_s.id     = ID_MAX_W'(idx_q);
                    evt_s.press  = sample_s[idx_q];
                end else begin
                    cnt_d[idx_q] = cnt_q[idx_q] + CW'(1);
                end
                if (idx_q == IDW'(N_SW - 1)) begin
                    state_d = IDLE;
                end else begin
                    idx_d = idx_q + IDW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // Sticky overflow: a drop in the same cycle as a clear keeps the flag set.
    always_comb begin
        ovf_d = ovf_q;
        if (push_s && full_s && !pop_s) begin
            ovf_d = 1'b1;
        end else if (OVF_CLR) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    sw_evt_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (CLK_33),
        .rst_i   (RST),
        .push_i  (push_s),
        .din_i   (evt_s),
        .pop_i   (pop_s),
        .full_o  (full_s),
        .empty_o (empty_s),
        .head_o  (head_s)
    );

    sw_debounce_chk u_chk (
        .clk_i  (CLK_33),
        .rst_i  (RST),
        .tick_i (tick_s),
        .scan_i (state_q == SCAN)
    );

    assign SW_STATE  = sw_q;
    assign EVT_OVF   = ovf_q;
    assign EVT_VALID = !empty_s;
    assign EVT_ID    = head_s.id[IDW-1:0] & {IDW{!empty_s}};
    assign EVT_PRESS = head_s.press & !empty_s;

endmodule
